// File: rtl/serial_gen_pkg.sv
// Purpose: shared state encoding and default geometry for the serial pattern generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_gen_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Defaults also used by the detector benches downstream.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

  // Prescaler needs at least one bit even when DIV=1.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/serial_pattern_gen_bit_timer.sv
// Purpose: DIV-cycle prescaler with synchronous clear; emits the per-bit strobe.
// Latency: stb is registered; high in the cycle the count sits at DIV-1.
// Backpressure: none; counts whenever run is high, held at 0 otherwise.
module bit_timer
  import serial_gen_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic stb
);

  localparam int            PW   = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          stb_q, stb_d;

  // Next count is the value seen in the coming cycle; the strobe is decoded from it so it stays registered.
  always_comb begin
    cnt_d = '0;
    if (!clr && run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    stb_d = run && (cnt_d == LAST);
  end

  // Prescaler and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      stb_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stb_q <= stb_d;
    end
  end

  assign stb = stb_q;

endmodule

// File: rtl/serial_pattern_gen.sv
// Purpose: latch a WIDTH-bit pattern on load and shift it out MSB first, DIV clocks per bit.
// Latency: first bit on data one cycle after load is sampled; done one cycle after the last strobe.
// Backpressure: none; load ignored while busy, stop aborts. SERIAL_GEN_LOOP_EN repeats the pattern.
module serial_pattern_gen
  import serial_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern,
  output logic             data,
  output logic             bit_stb,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bcnt_q, bcnt_d;
  logic             data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             start;
`ifdef SERIAL_GEN_LOOP_EN
  logic [WIDTH-1:0] copy_q, copy_d;
`endif

  bit_timer #(
    .DIV(DIV)
  ) u_bit_timer (
    .clk(clk),
    .rst(rst),
    .clr(start),
    .run(busy_d),
    .stb(bit_stb)
  );

  // Next-state logic: accept load in IDLE, shift on each strobe, finish or wrap after the last bit.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    done_d  = 1'b0;
    start   = 1'b0;
`ifdef SERIAL_GEN_LOOP_EN
    copy_d  = copy_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // stop outranks load so a simultaneous request leaves us idle.
        if (load && !stop) begin
          start   = 1'b1;
          state_d = ST_SHIFT;
          shift_d = pattern;
          bcnt_d  = '0;
`ifdef SERIAL_GEN_LOOP_EN
          copy_d  = pattern;
`endif
        end
      end
      ST_SHIFT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (bit_stb) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BIT) begin
            done_d = 1'b1;
`ifdef SERIAL_GEN_LOOP_EN
            shift_d = copy_q;
            bcnt_d  = '0;
`else
            state_d = ST_IDLE;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
    data_d = busy_d & shift_d[WIDTH-1];
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_GEN_LOOP_EN
      copy_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_GEN_LOOP_EN
      copy_q  <= copy_d;
`endif
    end
  end

  assign data = data_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
